// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : sub_pkg

// File: rtl/full_sub_bit.sv
// One-bit full subtractor built from two chained half subtractors: d = x - y - bin.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d_xy;
  logic b_xy;
  logic b_in;

  half_sub u_hs_xy (
    .x (x),
    .y (y),
    .d (d_xy),
    .b (b_xy)
  );

  half_sub u_hs_in (
    .x (d_xy),
    .y (bin),
    .d (d),
    .b (b_in)
  );

  // The two borrows are never both set, so OR is the exact carry-out.
  assign bout = b_xy | b_in;

endmodule : full_sub_bit

// File: rtl/half_sub.sv
// One-bit half subtractor: d = x - y, borrow when y exceeds x.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule : half_sub

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: computes a - b LSB first through a single full_sub_bit
// cell, presenting diff/borrow_out together with a one-cycle done pulse.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic             bff;
  logic [CW-1:0]    count;
  logic             d_bit;
  logic             b_bit;

  full_sub_bit u_full_sub_bit (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (bff),
    .d    (d_bit),
    .bout (b_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all registers here are flops (no memories), so all are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_r       <= '0;
      bff        <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_r  <= '0;
            bff   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sh_r  <= {d_bit, sh_r[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          bff   <= b_bit;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            // Fold the last bit in here so diff/borrow_out are valid while done is high.
            diff       <= {d_bit, sh_r[WIDTH-1:1]};
            borrow_out <= b_bit;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_sub_ctrl
